adder_seq_wide: RTL and testbench

Multi-cycle wide-operand adder sequencer that sits directly upstream of the registered 16-bit adder stage `adder_16bit`. It accepts WORDS×16-bit operands over a valid/ready handshake and issues them to the adder one 16-bit slice at a time, least significant first, chaining each slice's carry-out into the next slice's carry-in. It collects the slice sums into a wide result and returns it with the final carry and signed overflow over a second valid/ready handshake.

---
 rtl/adder_seq_pkg.sv | 18 +
 rtl/adder_seq_wide.sv | 123 ++++++++++++
 tb/tb_adder_seq_wide.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared types and sizing helpers for the wide-operand adder sequencer
package adder_seq_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // Width able to index n slices (or hold counts below n); never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_seq_wide.sv
// rtl/adder_seq_wide.sv - sequences WORDS x 16-bit slices through a registered adder; optional subtract via ADDER_SEQ_SUB_EN
module adder_seq_wide
    import adder_seq_pkg::*;
#(
    parameter int WORDS   = 4,
    parameter int ADD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*WORDS-1:0]   in_a,
    input  logic [SLICE_W*WORDS-1:0]   in_b,
    input  logic                       in_cin,
`ifdef ADDER_SEQ_SUB_EN
    input  logic                       in_sub,
`endif
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [SLICE_W*WORDS-1:0]   res_sum,
    output logic                       res_cout,
    output logic                       res_ovf,
    output logic [SLICE_W-1:0]         add_a,
    output logic [SLICE_W-1:0]         add_b,
    output logic                       add_cin,
    input  logic [SLICE_W-1:0]         add_sum,
    input  logic                       add_cout,
    input  logic                       add_ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam int CNT_W = idx_width(ADD_LAT + 1);

    seq_state_t         state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       a_lat;
    logic [W-1:0]       b_lat;
    logic [W-1:0]       b_eff;
    logic               cin_eff;

    // Subtraction is folded in at acceptance: store ~b and force slice-0 carry-in to 1.
`ifdef ADDER_SEQ_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;
`else
    assign b_eff   = in_b;
    assign cin_eff = in_cin;
`endif

    assign idx_nxt = idx + 1'b1;

    // Sequencer FSM and datapath: accept, issue each slice, wait out adder latency, collect, return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            a_lat     <= '0;
            b_lat     <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_ovf   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_cin   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        a_lat    <= in_a;
                        b_lat    <= b_eff;
                        add_a    <= in_a[SLICE_W-1:0];
                        add_b    <= b_eff[SLICE_W-1:0];
                        add_cin  <= cin_eff;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= CNT_W'(ADD_LAT);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt <= '0;
                        res_sum[int'(idx)*SLICE_W +: SLICE_W] <= add_sum;
                        if (idx == IDX_W'(WORDS - 1)) begin
                            res_cout  <= add_cout;
                            res_ovf   <= add_ovf;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            idx     <= idx_nxt;
                            add_a   <= a_lat[int'(idx_nxt)*SLICE_W +: SLICE_W];
                            add_b   <= b_lat[int'(idx_nxt)*SLICE_W +: SLICE_W];
                            add_cin <= add_cout;
                            state   <= ISSUE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_wide.sv
// tb/tb_adder_seq_wide.sv - directed self-checking bench for adder_seq_wide with a one-cycle adder model
module tb_adder_seq_wide;

    localparam int WORDS = 4;
    localparam int W     = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           in_cin;
`ifdef ADDER_SEQ_SUB_EN
    logic           in_sub;
`endif
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic           res_ovf;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic           add_cin;
    logic [15:0]    add_sum;
    logic           add_cout;
    logic           add_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    adder_seq_wide #(.WORDS(WORDS), .ADD_LAT(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
`ifdef ADDER_SEQ_SUB_EN
        .in_sub   (in_sub),
`endif
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_cout (res_cout),
        .res_ovf  (res_ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .add_ovf  (add_ovf)
    );

    // Registered 16-bit adder model, one cycle of latency.
    logic [16:0] m_full;
    always_comb m_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    always @(posedge clk) begin
        add_sum  <= m_full[15:0];
        add_cout <= m_full[16];
        add_ovf  <= (add_a[15] == add_b[15]) && (m_full[15] != add_a[15]);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for acceptance, then scramble inputs to prove they were latched.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic cin);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("accept_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        in_cin   = ~cin;
    endtask

    // Called #1 after the accept edge: counts edges to res_valid and records each slice's carry-in.
    task automatic wait_result(output int cyc, output logic [3:0] cins);
        cyc     = 0;
        cins    = 4'd0;
        cins[0] = add_cin;
        while (!res_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if ((cyc % 2) == 0 && cyc < 8) cins[cyc/2] = add_cin;
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("hs_valid_low", 64'(res_valid), 64'd0);
        check("hs_ready_high", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic [3:0]  cins;
        logic [63:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        res_ready = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
        in_sub    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_sum", res_sum, 64'd0);
        check("rst_add_a", 64'(add_a), 64'd0);
        check("rst_add_cin", 64'(add_cin), 64'd0);

        rst_n = 1'b1;
        #1;
        check("rdy_first_cycle", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", 64'(in_ready), 64'd1);

        // Carry out of slice 0 into slice 1.
        issue(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
        wait_result(cyc, cins);
        check("t1_latency", 64'(cyc), 64'd8);
        check("t1_sum", res_sum, 64'h0000_0000_0001_0000);
        check("t1_cout", 64'(res_cout), 64'd0);
        check("t1_ovf", 64'(res_ovf), 64'd0);
        check("t1_cins", 64'(cins), 64'h2);
        take_result();

        // Full carry ripple from cin to cout.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        wait_result(cyc, cins);
        check("t2_latency", 64'(cyc), 64'd8);
        check("t2_sum", res_sum, 64'h0);
        check("t2_cout", 64'(res_cout), 64'd1);
        check("t2_ovf", 64'(res_ovf), 64'd0);
        check("t2_cins", 64'(cins), 64'hF);
        take_result();

        // Signed overflow at the top slice, then back-pressure on the result.
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
        wait_result(cyc, cins);
        check("t3_sum", res_sum, 64'h8000_0000_0000_0000);
        check("t3_cout", 64'(res_cout), 64'd0);
        check("t3_ovf", 64'(res_ovf), 64'd1);
        held = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_sum", res_sum, held);
            check("hold_ovf", 64'(res_ovf), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end

        // Handshake with a request already pending: accepted on the following edge.
        @(negedge clk);
        res_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 64'h1234_5678_9ABC_DEF0;
        in_b      = 64'h1111_1111_1111_1111;
        in_cin    = 1'b0;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("b2b_valid_low", 64'(res_valid), 64'd0);
        check("b2b_ready_high", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("b2b_accepted", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        in_a     = {$urandom, $urandom};
        in_b     = {$urandom, $urandom};
        wait_result(cyc, cins);
        check("t4_latency", 64'(cyc), 64'd8);
        check("t4_sum", res_sum, 64'h2345_6789_ABCD_F001);
        check("t4_cout", 64'(res_cout), 64'd0);
        take_result();

        // Reset during WAIT of slice 2 aborts the operation.
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_add_a", 64'(add_a), 64'hFFFF);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 64'(in_ready), 64'd0);
        check("abort_res_valid", 64'(res_valid), 64'd0);
        check("abort_res_sum", res_sum, 64'd0);
        check("abort_res_cout", 64'(res_cout), 64'd0);
        check("abort_res_ovf", 64'(res_ovf), 64'd0);
        check("abort_add_a", 64'(add_a), 64'd0);
        check("abort_add_b", 64'(add_b), 64'd0);
        check("abort_add_cin", 64'(add_cin), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(64'h3, 64'h4, 1'b0);
        wait_result(cyc, cins);
        check("t5_latency", 64'(cyc), 64'd8);
        check("t5_sum", res_sum, 64'h7);
        check("t5_cout", 64'(res_cout), 64'd0);
        check("t5_ovf", 64'(res_ovf), 64'd0);
        take_result();

`ifdef ADDER_SEQ_SUB_EN
        in_sub = 1'b1;
        issue(64'h0, 64'h1, 1'b0);
        wait_result(cyc, cins);
        check("sub1_sum", res_sum, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub1_cout", 64'(res_cout), 64'd0);
        check("sub1_ovf", 64'(res_ovf), 64'd0);
        take_result();

        in_sub = 1'b1;
        issue(64'h8000_0000_0000_0000, 64'h1, 1'b0);
        wait_result(cyc, cins);
        check("sub2_sum", res_sum, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub2_cout", 64'(res_cout), 64'd1);
        check("sub2_ovf", 64'(res_ovf), 64'd1);
        take_result();
        in_sub = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
